uart_cmd_frontend: RTL and testbench
====================================

Name: uart_cmd_frontend

Overview:
Command initiator that drives the FIFO controller's command interface. It parses framed command headers from the UART receive byte stream and presents cmd/rx_cnt to the controller. It then tracks the controller through busy/done and returns it to idle with a fe_done handshake. It sits between the UART receiver and the FIFO controller. Payload bytes after a header are left to the controller, so the front end ignores rx_valid while a command is in flight.

Parameters:
SOF, 8'hA5, start-of-frame byte
BYTE_TO, 50000, max clk cycles between consecutive header bytes (1 ms at 50 MHz)
ISSUE_TO, 1000, max clk cycles from cmd assertion to fifo_busy rising
CNT_W, 16, width of the length field and rx_cnt

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  reset; synchronous, active-high
rx_byte  in  8  received UART byte
rx_valid  in  1  one-cycle strobe; rx_byte valid
fifo_busy  in  1  controller not idle
fifo_done  in  1  controller in done state
cmd  out  8  command code to controller; 8'h00 = none
rx_cnt  out  CNT_W  byte count for the command
fe_done  out  1  releases the controller from done back to idle
frame_err  out  1  one-cycle pulse on any rejected frame
frame_cnt  out  8  accepted frames, wraps
err_cnt  out  8  rejected frames, saturates at 8'hFF

Behaviour:
- Reset: all outputs 0 and state IDLE; timers cleared. Reset asserted mid-frame or mid-command wins, and cmd reads 0 from the next edge.
- Frame format: SOF, CMD, LEN_H, LEN_L, CHK, where CHK = CMD^LEN_H^LEN_L. Legal CMD values are 8'h01 (rx→tx loop), 8'h02 (sd init) and 8'h03 (sd read). Cmd 03 still carries the LEN bytes; rx_cnt is driven but unused by the controller.
- States:
  - IDLE: a byte equal to SOF → GET_CMD. Any other byte is silently dropped (hunt mode).
  - GET_CMD: latch the byte → GET_LH.
  - GET_LH: latch the byte → GET_LL.
  - GET_LL: latch the byte → GET_CHK.
  - GET_CHK: on the byte, compare it to the computed XOR.
    - Mismatch, or illegal CMD → frame_err pulse, err_cnt++, → IDLE.
    - Otherwise → ISSUE, with rx_cnt <= {LEN_H, LEN_L} and cmd <= CMD on the same edge.
  - ISSUE: hold cmd until fifo_busy is sampled 1, then cmd <= 0, frame_cnt++, → RUN. If ISSUE_TO cycles elapse with fifo_busy still 0 → cmd <= 0, frame_err, err_cnt++, → IDLE.
  - RUN: wait for fifo_done=1 → DONE_ACK with fe_done <= 1.
  - DONE_ACK: hold fe_done until fifo_busy is sampled 0, then fe_done <= 0 → IDLE.
- Latency: cmd is valid on the edge after the CHK byte strobe. fe_done rises on the edge after fifo_done is first sampled high.
- Byte timeout (GET_CMD..GET_CHK only):
  - The counter reloads on every rx_valid.
  - Reaching BYTE_TO → frame_err, err_cnt++, → IDLE.
  - rx_valid in the same cycle as expiry: the byte wins and the timer reloads.
- rx_valid is ignored in ISSUE, RUN and DONE_ACK; those bytes are payload for the controller.
- rx_cnt stays stable from ISSUE through DONE_ACK and holds its last value in IDLE.
- cmd is never nonzero outside ISSUE, so the controller cannot re-trigger when it returns to idle.
- fifo_done seen in ISSUE (controller finished within the busy-detect cycle): treat it as fifo_busy, and go to RUN, which then exits immediately.
- Counters: frame_cnt wraps 8'hFF→8'h00. err_cnt holds at 8'hFF. frame_err and the err_cnt increment occur in the same cycle.

Decomposition:
- Shared package uart_fifo_pkg holds:
  - command codes CMD_NONE=8'h00, CMD_LOOP=8'h01, CMD_SD_INIT=8'h02, CMD_SD_READ=8'h03
  - the SOF default
  - the state encoding (IDLE..DONE_ACK)
  The FIFO controller side imports the same codes.
- One sub-module, fe_timer: a loadable down-counter with reload/enable and an expire flag. It is instantiated twice, for BYTE_TO and ISSUE_TO.

Test Plan:
- Frame A5 01 00 04 05, with fifo_busy modelled rising 3 cycles later → cmd=8'h01 and rx_cnt=16'h0004 until busy, then cmd=0. On fifo_done, fe_done=1 until busy falls. frame_cnt=1.
- Frame A5 01 00 04 06 (bad CHK) → frame_err pulse, err_cnt=1, cmd stays 0; a following valid frame is accepted.
- Bytes 00 FF A5 02 12 34 24 → the leading bytes are dropped. cmd=8'h02, rx_cnt=16'h1234.
- A5 01, then no byte for BYTE_TO cycles → frame_err and IDLE. A byte arriving exactly on the expiry cycle does not abort the frame.
- Valid frame with fifo_busy held 0 → cmd drops after ISSUE_TO cycles, frame_err, err_cnt=1. Illegal CMD 8'h07 with correct CHK → rejected.
- Assert rst during RUN → all outputs 0 next edge. 256 errors → err_cnt saturates at 8'hFF. 256 accepted frames → frame_cnt wraps to 0.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// Shared definitions between the UART command front end and the FIFO controller:
// command codes, default start-of-frame byte and the front-end state encoding.
package uart_fifo_pkg;

    localparam logic [7:0] CMD_NONE    = 8'h00;
    localparam logic [7:0] CMD_LOOP    = 8'h01;
    localparam logic [7:0] CMD_SD_INIT = 8'h02;
    localparam logic [7:0] CMD_SD_READ = 8'h03;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_LH,
        GET_LL,
        GET_CHK,
        ISSUE,
        RUN,
        DONE_ACK
    } fe_state_t;

    // Only the three command codes the controller understands are accepted.
    function automatic logic is_legal_cmd(input logic [7:0] code);
        return (code == CMD_LOOP) || (code == CMD_SD_INIT) || (code == CMD_SD_READ);
    endfunction

endpackage

// File: rtl/fe_timer.sv
// Loadable down-counter used for the inter-byte and command-issue timeouts.
// After a load of N-1 the expire flag rises on the N-th enabled cycle.
module fe_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         enable,
    output logic         expired
);

    logic [W-1:0] count;

    // Reload has priority; otherwise count down while enabled and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired = enable && (count == '0);

endmodule

// File: rtl/uart_cmd_frontend.sv
// UART command front end: hunts for framed headers (SOF CMD LEN_H LEN_L CHK),
// issues the command to the FIFO controller and walks it through busy/done,
// releasing it with fe_done. Payload bytes during a command belong to the controller.
module uart_cmd_frontend
    import uart_fifo_pkg::*;
#(
    parameter logic [7:0] SOF      = SOF_DEFAULT,
    parameter int         BYTE_TO  = 50000,
    parameter int         ISSUE_TO = 1000,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    input  logic             fifo_busy,
    input  logic             fifo_done,
    output logic [7:0]       cmd,
    output logic [CNT_W-1:0] rx_cnt,
    output logic             fe_done,
    output logic             frame_err,
    output logic [7:0]       frame_cnt,
    output logic [7:0]       err_cnt
);

    localparam int BT_W = $clog2(BYTE_TO + 1);
    localparam int IT_W = $clog2(ISSUE_TO + 1);

    fe_state_t        state, state_d;
    logic [7:0]       cmd_byte, cmd_byte_d;
    logic [7:0]       len_h, len_h_d;
    logic [7:0]       len_l, len_l_d;
    logic [7:0]       cmd_d;
    logic [CNT_W-1:0] rx_cnt_d;
    logic             fe_done_d;
    logic [7:0]       frame_cnt_d;
    logic             err_hit;
    logic             byte_load, byte_en, byte_exp;
    logic             issue_load, issue_en, issue_exp;

    assign byte_en  = (state == GET_CMD) || (state == GET_LH) ||
                      (state == GET_LL)  || (state == GET_CHK);
    assign issue_en = (state == ISSUE);

    fe_timer #(.W(BT_W)) u_byte_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (byte_load),
        .load_val (BT_W'(BYTE_TO - 1)),
        .enable   (byte_en),
        .expired  (byte_exp)
    );

    fe_timer #(.W(IT_W)) u_issue_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (issue_load),
        .load_val (IT_W'(ISSUE_TO - 1)),
        .enable   (issue_en),
        .expired  (issue_exp)
    );

    // Next-state and next-output logic; an arriving byte always beats a timer expiry.
    always_comb begin
        state_d     = state;
        cmd_byte_d  = cmd_byte;
        len_h_d     = len_h;
        len_l_d     = len_l;
        cmd_d       = cmd;
        rx_cnt_d    = rx_cnt;
        fe_done_d   = fe_done;
        frame_cnt_d = frame_cnt;
        err_hit     = 1'b0;
        byte_load   = 1'b0;
        issue_load  = 1'b0;

        case (state)
            IDLE: begin
                if (rx_valid && (rx_byte == SOF)) begin
                    byte_load = 1'b1;
                    state_d   = GET_CMD;
                end
            end
            GET_CMD: begin
                if (rx_valid) begin
                    byte_load  = 1'b1;
                    cmd_byte_d = rx_byte;
                    state_d    = GET_LH;
                end else if (byte_exp) begin
                    err_hit = 1'b1;
                    state_d = IDLE;
                end
            end
            GET_LH: begin
                if (rx_valid) begin
                    byte_load = 1'b1;
                    len_h_d   = rx_byte;
                    state_d   = GET_LL;
                end else if (byte_exp) begin
                    err_hit = 1'b1;
                    state_d = IDLE;
                end
            end
            GET_LL: begin
                if (rx_valid) begin
                    byte_load = 1'b1;
                    len_l_d   = rx_byte;
                    state_d   = GET_CHK;
                end else if (byte_exp) begin
                    err_hit = 1'b1;
                    state_d = IDLE;
                end
            end
            GET_CHK: begin
                if (rx_valid) begin
                    if ((rx_byte != (cmd_byte ^ len_h ^ len_l)) || !is_legal_cmd(cmd_byte)) begin
                        err_hit = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cmd_d      = cmd_byte;
                        rx_cnt_d   = CNT_W'({len_h, len_l});
                        issue_load = 1'b1;
                        state_d    = ISSUE;
                    end
                end else if (byte_exp) begin
                    err_hit = 1'b1;
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (fifo_busy || fifo_done) begin
                    cmd_d       = CMD_NONE;
                    frame_cnt_d = frame_cnt + 8'd1;
                    state_d     = RUN;
                end else if (issue_exp) begin
                    cmd_d   = CMD_NONE;
                    err_hit = 1'b1;
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (fifo_done) begin
                    fe_done_d = 1'b1;
                    state_d   = DONE_ACK;
                end
            end
            DONE_ACK: begin
                if (!fifo_busy) begin
                    fe_done_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                cmd_d     = CMD_NONE;
                fe_done_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and registered outputs; the error pulse and saturating count move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_byte  <= 8'h00;
            len_h     <= 8'h00;
            len_l     <= 8'h00;
            cmd       <= CMD_NONE;
            rx_cnt    <= '0;
            fe_done   <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= 8'h00;
            err_cnt   <= 8'h00;
        end else begin
            state     <= state_d;
            cmd_byte  <= cmd_byte_d;
            len_h     <= len_h_d;
            len_l     <= len_l_d;
            cmd       <= cmd_d;
            rx_cnt    <= rx_cnt_d;
            fe_done   <= fe_done_d;
            frame_err <= err_hit;
            frame_cnt <= frame_cnt_d;
            if (err_hit && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_frontend.sv
// Self-checking bench for uart_cmd_frontend: directed scenarios plus randomized
// frames, checked against a frame-level reference model kept in the bench.
module tb_uart_cmd_frontend;

    localparam int BTO = 40;
    localparam int ITO = 24;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        fifo_busy;
    logic        fifo_done;
    logic [7:0]  cmd;
    logic [15:0] rx_cnt;
    logic        fe_done;
    logic        frame_err;
    logic [7:0]  frame_cnt;
    logic [7:0]  err_cnt;

    int          vectors;
    int          miscompares;
    logic [7:0]  frameModel;
    logic [7:0]  errModel;
    logic [15:0] lastCnt;

    uart_cmd_frontend #(
        .SOF      (8'hA5),
        .BYTE_TO  (BTO),
        .ISSUE_TO (ITO),
        .CNT_W    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .fifo_busy (fifo_busy),
        .fifo_done (fifo_done),
        .cmd       (cmd),
        .rx_cnt    (rx_cnt),
        .fe_done   (fe_done),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Hard bound on total run time.
    initial begin
        #20000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Frame-level rules: legal command code and XOR checksum.
    function automatic logic [7:0] chkOf(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
        return c ^ h ^ l;
    endfunction

    function automatic bit frameAccepted(input logic [7:0] c, input logic [7:0] h,
                                         input logic [7:0] l, input logic [7:0] k);
        return (c >= 8'h01) && (c <= 8'h03) && (k == chkOf(c, h, l));
    endfunction

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one byte (or an idle cycle) for a single clock.
    task automatic applyStimulus(input logic [7:0] b, input logic v);
        rx_byte  = b;
        rx_valid = v;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0);
    endtask

    task automatic sendFrame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                             input logic [7:0] k, input int noise, input int gapMax);
        logic [7:0] nb;
        for (int i = 0; i < noise; i++) begin
            nb = 8'($urandom_range(0, 255));
            if (nb == 8'hA5) nb = 8'h5A;
            applyStimulus(nb, 1'b1);
        end
        applyStimulus(8'hA5, 1'b1);
        idleCycles($urandom_range(0, gapMax));
        applyStimulus(c, 1'b1);
        idleCycles($urandom_range(0, gapMax));
        applyStimulus(h, 1'b1);
        idleCycles($urandom_range(0, gapMax));
        applyStimulus(l, 1'b1);
        idleCycles($urandom_range(0, gapMax));
        applyStimulus(k, 1'b1);
    endtask

    // Behavioural controller: busy after busyDelay cycles, done after runLen, released by fe_done.
    task automatic runCommand(input logic [7:0] expCmd, input logic [15:0] expCnt,
                              input int busyDelay, input int runLen);
        lastCnt = expCnt;
        checkOutput("cmd_issue", {24'd0, cmd}, {24'd0, expCmd});
        checkOutput("rx_cnt_issue", {16'd0, rx_cnt}, {16'd0, expCnt});
        for (int i = 0; i < busyDelay; i++) begin
            step();
            checkOutput("cmd_hold", {24'd0, cmd}, {24'd0, expCmd});
        end
        fifo_busy = 1'b1;
        step();
        frameModel = frameModel + 8'd1;
        checkOutput("cmd_clear", {24'd0, cmd}, 32'd0);
        checkOutput("frame_cnt", {24'd0, frame_cnt}, {24'd0, frameModel});
        for (int i = 0; i < runLen; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                rx_byte  = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
                rx_valid = 1'b1;
            end
            step();
            rx_valid = 1'b0;
            checkOutput("run_fe_done", {31'd0, fe_done}, 32'd0);
            checkOutput("run_cmd", {24'd0, cmd}, 32'd0);
        end
        fifo_done = 1'b1;
        step();
        checkOutput("fe_done_rise", {31'd0, fe_done}, 32'd1);
        step();
        checkOutput("fe_done_hold", {31'd0, fe_done}, 32'd1);
        fifo_busy = 1'b0;
        fifo_done = 1'b0;
        step();
        checkOutput("fe_done_fall", {31'd0, fe_done}, 32'd0);
        checkOutput("rx_cnt_idle", {16'd0, rx_cnt}, {16'd0, lastCnt});
        checkOutput("err_cnt_run", {24'd0, err_cnt}, {24'd0, errModel});
    endtask

    task automatic checkRejected(input string tag);
        errModel = satInc(errModel);
        checkOutput({tag, "_frame_err"}, {31'd0, frame_err}, 32'd1);
        checkOutput({tag, "_err_cnt"}, {24'd0, err_cnt}, {24'd0, errModel});
        checkOutput({tag, "_cmd"}, {24'd0, cmd}, 32'd0);
        checkOutput({tag, "_rx_cnt"}, {16'd0, rx_cnt}, {16'd0, lastCnt});
        step();
        checkOutput({tag, "_pulse_end"}, {31'd0, frame_err}, 32'd0);
    endtask

    task automatic processFrame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                                input logic [7:0] k, input int noise, input int gapMax,
                                input int busyDelay, input int runLen);
        sendFrame(c, h, l, k, noise, gapMax);
        if (frameAccepted(c, h, l, k)) runCommand(c, {h, l}, busyDelay, runLen);
        else checkRejected("rand_reject");
    endtask

    initial begin
        logic [7:0] c, h, l, k;
        int kind;
        vectors     = 0;
        miscompares = 0;
        frameModel  = 8'h00;
        errModel    = 8'h00;
        lastCnt     = 16'h0000;
        rst         = 1'b1;
        rx_byte     = 8'h00;
        rx_valid    = 1'b0;
        fifo_busy   = 1'b0;
        fifo_done   = 1'b0;
        step();
        step();
        checkOutput("rst_cmd", {24'd0, cmd}, 32'd0);
        checkOutput("rst_rx_cnt", {16'd0, rx_cnt}, 32'd0);
        checkOutput("rst_fe_done", {31'd0, fe_done}, 32'd0);
        checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        checkOutput("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        step();

        $display("[TB] basic frame A5 01 00 04 05");
        sendFrame(8'h01, 8'h00, 8'h04, 8'h05, 0, 0);
        runCommand(8'h01, 16'h0004, 3, 6);

        $display("[TB] bad checksum then valid frame");
        sendFrame(8'h01, 8'h00, 8'h04, 8'h06, 0, 0);
        checkRejected("bad_chk");
        sendFrame(8'h03, 8'hBE, 8'hEF, chkOf(8'h03, 8'hBE, 8'hEF), 0, 0);
        runCommand(8'h03, 16'hBEEF, 1, 2);

        $display("[TB] hunt mode drops leading bytes");
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        sendFrame(8'h02, 8'h12, 8'h34, 8'h24, 0, 0);
        runCommand(8'h02, 16'h1234, 0, 3);

        $display("[TB] inter-byte timeout");
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h01, 1'b1);
        idleCycles(BTO - 1);
        checkOutput("byte_to_early", {31'd0, frame_err}, 32'd0);
        idleCycles(1);
        checkRejected("byte_to");

        $display("[TB] byte arriving on the expiry cycle");
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h01, 1'b1);
        idleCycles(BTO - 1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("byte_to_exact", {31'd0, frame_err}, 32'd0);
        applyStimulus(8'h04, 1'b1);
        applyStimulus(8'h05, 1'b1);
        runCommand(8'h01, 16'h0004, 2, 1);

        $display("[TB] issue timeout with busy held low");
        sendFrame(8'h02, 8'h00, 8'h10, chkOf(8'h02, 8'h00, 8'h10), 0, 0);
        lastCnt = 16'h0010;
        checkOutput("issue_cmd", {24'd0, cmd}, 32'h02);
        idleCycles(ITO - 1);
        checkOutput("issue_to_hold", {24'd0, cmd}, 32'h02);
        idleCycles(1);
        checkRejected("issue_to");
        checkOutput("issue_to_frame_cnt", {24'd0, frame_cnt}, {24'd0, frameModel});

        $display("[TB] illegal command with correct checksum");
        sendFrame(8'h07, 8'h00, 8'h01, 8'h06, 0, 0);
        checkRejected("illegal_cmd");

        $display("[TB] done seen while still in issue");
        sendFrame(8'h01, 8'h00, 8'h02, 8'h03, 0, 0);
        lastCnt   = 16'h0002;
        fifo_done = 1'b1;
        step();
        frameModel = frameModel + 8'd1;
        checkOutput("fast_cmd_clear", {24'd0, cmd}, 32'd0);
        checkOutput("fast_frame_cnt", {24'd0, frame_cnt}, {24'd0, frameModel});
        step();
        checkOutput("fast_fe_done", {31'd0, fe_done}, 32'd1);
        fifo_done = 1'b0;
        step();
        checkOutput("fast_fe_release", {31'd0, fe_done}, 32'd0);

        $display("[TB] randomized frames");
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            c = 8'($urandom_range(1, 3));
            h = 8'($urandom_range(0, 255));
            l = 8'($urandom_range(0, 255));
            k = chkOf(c, h, l);
            if (kind == 1) k = k ^ 8'($urandom_range(1, 255));
            if (kind == 2) begin
                c = 8'($urandom_range(4, 255));
                k = chkOf(c, h, l);
            end
            processFrame(c, h, l, k, (kind == 3) ? $urandom_range(1, 4) : 0, 3,
                         $urandom_range(0, ITO - 1), $urandom_range(0, 8));
        end

        $display("[TB] reset during run");
        sendFrame(8'h01, 8'hAA, 8'h55, chkOf(8'h01, 8'hAA, 8'h55), 0, 0);
        fifo_busy = 1'b1;
        step();
        rst = 1'b1;
        step();
        checkOutput("rstrun_cmd", {24'd0, cmd}, 32'd0);
        checkOutput("rstrun_rx_cnt", {16'd0, rx_cnt}, 32'd0);
        checkOutput("rstrun_fe_done", {31'd0, fe_done}, 32'd0);
        checkOutput("rstrun_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        checkOutput("rstrun_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst        = 1'b0;
        fifo_busy  = 1'b0;
        frameModel = 8'h00;
        errModel   = 8'h00;
        lastCnt    = 16'h0000;
        step();

        $display("[TB] frame counter wrap");
        for (int n = 0; n < 256; n++) begin
            h = 8'($urandom_range(0, 255));
            l = 8'($urandom_range(0, 255));
            sendFrame(8'h02, h, l, chkOf(8'h02, h, l), 0, 0);
            runCommand(8'h02, {h, l}, 0, 0);
        end
        checkOutput("frame_cnt_wrap", {24'd0, frame_cnt}, 32'd0);

        $display("[TB] error counter saturation");
        for (int n = 0; n < 300; n++) begin
            sendFrame(8'h01, 8'h00, 8'h00, 8'h00, 0, 0);
            checkRejected("sat");
        end
        checkOutput("err_cnt_sat", {24'd0, err_cnt}, 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
